// File: rtl/pipeline_defs.sv
// rtl/pipeline_defs.sv - shared constants, types and helpers for the RV32I pipeline
//
// Contents:
//   XLEN           datapath width (32)
//   RESET_PC       PC loaded on reset
//   NOP_INST       addi x0,x0,0, inserted on bubble or flush
//   fetch_state_e  fetch FSM encoding (REQ=0, WAIT=1, DROP=2, HOLD=3)
//   align_word()   clears address bits [1:0]
package pipeline_defs;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC = 32'h0000_3000;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - inter-stage pipeline register with flush > stall > load > bubble priority
//
// Ports:
//   clk, rstn         clock, asynchronous active-low reset
//   flush_i           squash: valid cleared, instruction replaced by NOP
//   stall_i           hold every field
//   load_i            capture pc_i/inst_i and mark valid
//   pc_i, inst_i      incoming PC and instruction
//   pc_o, inst_o      registered PC and instruction
//   valid_o           register holds a real instruction
// With no flush, stall or load the stage becomes a bubble; the PC field is
// left untouched so a bubble keeps pointing at the last real instruction.
module if_id_reg
  import pipeline_defs::*;
#(
  parameter int                PC_W   = XLEN,
  parameter int                INST_W = XLEN,
  parameter logic [INST_W-1:0] NOP    = NOP_INST
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              load_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic [PC_W-1:0]   pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              valid_o
);

  logic [PC_W-1:0]   pc_q,    pc_d;
  logic [INST_W-1:0] inst_q,  inst_d;
  logic              valid_q, valid_d;

  always_comb begin
    pc_d    = pc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = 1'b0;
      inst_d  = NOP;
    end else if (stall_i) begin
      // hold all fields
    end else if (load_i) begin
      pc_d    = pc_i;
      inst_d  = inst_i;
      valid_d = 1'b1;
    end else begin
      valid_d = 1'b0;
      inst_d  = NOP;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q    <= '0;
      inst_q  <= NOP;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

  assign pc_o    = pc_q;
  assign inst_o  = inst_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I IF stage with single-outstanding imem fetch and IF/ID register
//
// Optional feature macro: FETCH_PERF_EN (adds perf_fetched / perf_wait counters)
//
// Ports:
//   clk, rstn                    clock, asynchronous active-low reset
//   IF_stall                     hold PC and any fetched instruction
//   ID_stall                     hold the IF/ID register
//   ID_flush                     squash the IF/ID register
//   jmp_EX, jmp_target           EX-stage redirect and its target (bits [1:0] ignored)
//   imem_req, imem_addr          instruction memory request (address is the PC)
//   imem_ready                   memory accepts the request this cycle
//   imem_resp_valid, imem_rdata  instruction memory response
//   id_pc, id_inst, id_valid     IF/ID register contents for decode
//   fetch_busy                   a request is outstanding (WAIT or DROP)
//   perf_fetched, perf_wait      [FETCH_PERF_EN] deliveries / busy cycles, wrapping
module fetch_unit
  import pipeline_defs::*;
#(
  parameter logic [31:0] RESET_PC = pipeline_defs::RESET_PC,
  parameter logic [31:0] NOP_INST = pipeline_defs::NOP_INST
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        IF_stall,
  input  logic        ID_stall,
  input  logic        ID_flush,
  input  logic        jmp_EX,
  input  logic [31:0] jmp_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_valid,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_wait,
`endif
  output logic        fetch_busy
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  skid_inst_q, skid_inst_d;
  logic [31:0]  skid_pc_q, skid_pc_d;

  logic         deliver;
  logic [31:0]  deliver_pc;
  logic [31:0]  deliver_inst;
  logic [31:0]  redirect_pc;

  assign redirect_pc = align_word(jmp_target);

  // Redirect always wins over IF_stall; a delivery is never produced in a
  // redirect cycle, so a squashed path cannot reach ID.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    imem_req     = 1'b0;
    deliver      = 1'b0;
    deliver_pc   = pc_q;
    deliver_inst = imem_rdata;

    case (state_q)
      S_REQ: begin
        imem_req = 1'b1;
        if (jmp_EX) begin
          pc_d = redirect_pc;
          // an accepted request now belongs to the old path; wait it out
          if (imem_ready) state_d = S_DROP;
        end else if (imem_ready) begin
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (imem_resp_valid) begin
          if (jmp_EX) begin
            pc_d    = redirect_pc;
            state_d = S_REQ;
          end else if (IF_stall) begin
            skid_inst_d = imem_rdata;
            skid_pc_d   = pc_q;
            state_d     = S_HOLD;
          end else begin
            deliver      = 1'b1;
            deliver_inst = imem_rdata;
            deliver_pc   = pc_q;
            pc_d         = pc_q + 32'd4;
            state_d      = S_REQ;
          end
        end else if (jmp_EX) begin
          pc_d    = redirect_pc;
          state_d = S_DROP;
        end
      end

      S_DROP: begin
        if (jmp_EX) pc_d = redirect_pc;
        if (imem_resp_valid) state_d = S_REQ;
      end

      S_HOLD: begin
        if (jmp_EX) begin
          skid_inst_d = NOP_INST;
          pc_d        = redirect_pc;
          state_d     = S_REQ;
        end else if (!IF_stall) begin
          deliver      = 1'b1;
          deliver_inst = skid_inst_q;
          deliver_pc   = skid_pc_q;
          pc_d         = pc_q + 32'd4;
          state_d      = S_REQ;
        end
      end

      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      skid_inst_q <= NOP_INST;
      skid_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

  assign imem_addr  = pc_q;
  assign fetch_busy = (state_q == S_WAIT) || (state_q == S_DROP);

  if_id_reg #(
    .PC_W   (32),
    .INST_W (32),
    .NOP    (NOP_INST)
  ) u_if_id (
    .clk     (clk),
    .rstn    (rstn),
    .flush_i (ID_flush | jmp_EX),
    .stall_i (ID_stall),
    .load_i  (deliver),
    .pc_i    (deliver_pc),
    .inst_i  (deliver_inst),
    .pc_o    (id_pc),
    .inst_o  (id_inst),
    .valid_o (id_valid)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_wait_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_fetched_q <= '0;
      perf_wait_q    <= '0;
    end else begin
      if (deliver)    perf_fetched_q <= perf_fetched_q + 32'd1;
      if (fetch_busy) perf_wait_q    <= perf_wait_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_wait    = perf_wait_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a behavioural model
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rstn;
  logic        IF_stall, ID_stall, ID_flush, jmp_EX;
  logic [31:0] jmp_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready, imem_resp_valid;
  logic [31:0] imem_rdata;
  logic [31:0] id_pc, id_inst;
  logic        id_valid, fetch_busy;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_wait;
`endif

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk             (clk),
    .rstn            (rstn),
    .IF_stall        (IF_stall),
    .ID_stall        (ID_stall),
    .ID_flush        (ID_flush),
    .jmp_EX          (jmp_EX),
    .jmp_target      (jmp_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_rdata      (imem_rdata),
    .id_pc           (id_pc),
    .id_inst         (id_inst),
    .id_valid        (id_valid),
`ifdef FETCH_PERF_EN
    .perf_fetched    (perf_fetched),
    .perf_wait       (perf_wait),
`endif
    .fetch_busy      (fetch_busy)
  );

  int checks = 0;
  int errors = 0;

  // reference model: a request is either in flight or not, its answer is
  // either wanted or stale, and at most one fetched word waits in a side buffer
  logic [31:0] m_pc;
  bit          m_inflight, m_stale, m_held;
  logic [31:0] m_held_inst, m_held_pc;
  bit          m_id_valid;
  logic [31:0] m_id_pc, m_id_inst;
  logic [31:0] m_fetched, m_wait;

  // memory model: one pending request, answered after mem_delay cycles
  bit          mem_pending;
  logic [31:0] mem_addr;
  int          mem_delay;

  // stimulus knobs (percentages)
  int p_stall, p_idstall, p_flush, p_jmp, p_ready, max_delay;

  bit          log_en;
  int          n_acc;
  logic [31:0] acc [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  task automatic model_reset();
    m_pc        = RST_PC;
    m_inflight  = 0;
    m_stale     = 0;
    m_held      = 0;
    m_held_inst = NOP;
    m_held_pc   = '0;
    m_id_valid  = 0;
    m_id_pc     = '0;
    m_id_inst   = NOP;
    m_fetched   = '0;
    m_wait      = '0;
    mem_pending = 0;
    mem_addr    = '0;
    mem_delay   = 0;
  endtask

  task automatic check_outputs();
    check("imem_req",   imem_req,   (!m_inflight && !m_held) ? 32'd1 : 32'd0);
    check("imem_addr",  imem_addr,  m_pc);
    check("fetch_busy", fetch_busy, m_inflight ? 32'd1 : 32'd0);
    check("id_valid",   id_valid,   m_id_valid ? 32'd1 : 32'd0);
    check("id_pc",      id_pc,      m_id_pc);
    check("id_inst",    id_inst,    m_id_inst);
`ifdef FETCH_PERF_EN
    check("perf_fetched", perf_fetched, m_fetched);
    check("perf_wait",    perf_wait,    m_wait);
`endif
  endtask

  task automatic drive_inputs();
    rstn     = 1'b1;
    IF_stall = ($urandom_range(99) < p_stall);
    ID_stall = ($urandom_range(99) < p_idstall);
    ID_flush = ($urandom_range(99) < p_flush);
    jmp_EX   = ($urandom_range(99) < p_jmp);
    case ($urandom_range(3))
      0:       jmp_target = 32'h0000_3040;
      1:       jmp_target = 32'hFFFF_FFFC | $urandom_range(3);
      2:       jmp_target = $urandom;
      default: jmp_target = 32'h0000_3000 + ($urandom_range(63) << 2) + $urandom_range(3);
    endcase
    imem_ready      = ($urandom_range(99) < p_ready);
    imem_resp_valid = mem_pending && (mem_delay == 0);
    imem_rdata      = imem_resp_valid ? mem_word(mem_addr) : $urandom;
  endtask

  task automatic step_model();
    bit          was_held, was_inflight, req, accept, dlv;
    logic [31:0] old_pc, tgt, dinst, dpc;
    was_held     = m_held;
    was_inflight = m_inflight;
    old_pc       = m_pc;
    req          = !m_inflight && !m_held;
    accept       = req && imem_ready;
    tgt          = jmp_target & 32'hFFFF_FFFC;
    dlv          = 0;
    dinst        = '0;
    dpc          = '0;

    if (m_inflight && imem_resp_valid) begin
      m_inflight = 0;
      if (!m_stale && !jmp_EX) begin
        if (IF_stall) begin
          m_held      = 1;
          m_held_inst = imem_rdata;
          m_held_pc   = old_pc;
        end else begin
          dlv   = 1;
          dinst = imem_rdata;
          dpc   = old_pc;
        end
      end
      m_stale = 0;
    end else if (accept) begin
      m_inflight = 1;
      m_stale    = 0;
    end

    if (was_held) begin
      if (jmp_EX) m_held = 0;
      else if (!IF_stall) begin
        dlv    = 1;
        dinst  = m_held_inst;
        dpc    = m_held_pc;
        m_held = 0;
      end
    end

    if (jmp_EX) begin
      m_pc = tgt;
      if (m_inflight) m_stale = 1;
    end else if (dlv) begin
      m_pc = old_pc + 32'd4;
    end

    if (dlv) m_fetched = m_fetched + 1;
    if (was_inflight) m_wait = m_wait + 1;

    if (ID_flush || jmp_EX) begin
      m_id_valid = 0;
      m_id_inst  = NOP;
    end else if (ID_stall) begin
    end else if (dlv) begin
      m_id_valid = 1;
      m_id_pc    = dpc;
      m_id_inst  = dinst;
    end else begin
      m_id_valid = 0;
      m_id_inst  = NOP;
    end

    if (accept) begin
      mem_pending = 1;
      mem_addr    = old_pc;
      mem_delay   = $urandom_range(max_delay);
      if (log_en && n_acc < 3) begin
        acc[n_acc] = old_pc;
        n_acc++;
      end
    end else if (mem_pending) begin
      if (imem_resp_valid) mem_pending = 0;
      else mem_delay--;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    drive_inputs();
    @(posedge clk);
    step_model();
  endtask

  task automatic quiet_inputs();
    IF_stall        = 1'b0;
    ID_stall        = 1'b0;
    ID_flush        = 1'b0;
    jmp_EX          = 1'b0;
    jmp_target      = '0;
    imem_ready      = 1'b0;
    imem_resp_valid = 1'b0;
    imem_rdata      = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    quiet_inputs();
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic set_knobs(input int st, input int ids, input int fl, input int jp,
                           input int rd, input int md);
    p_stall   = st;
    p_idstall = ids;
    p_flush   = fl;
    p_jmp     = jp;
    p_ready   = rd;
    max_delay = md;
  endtask

  initial begin
    rstn = 1'b0;
    quiet_inputs();
    model_reset();
    log_en = 0;
    n_acc  = 0;
    set_knobs(0, 0, 0, 0, 100, 0);

    repeat (2) @(negedge clk);
    check("rst_id_valid", id_valid, 32'd0);
    check("rst_id_inst",  id_inst,  NOP);
    check("rst_id_pc",    id_pc,    32'd0);
    check("rst_pc",       imem_addr, RST_PC);

    // zero-wait memory, no hazards: addresses step by 4 from the reset PC
    log_en = 1;
    repeat (12) cycle();
    log_en = 0;
    for (int i = 0; i < 3; i++) begin
      logic [31:0] want;
      want = RST_PC + 32'(4 * i);
      check($sformatf("seq_addr%0d", i), (i < n_acc) ? acc[i] : 32'hDEAD_BEEF, want);
    end

    for (int ph = 0; ph < 6; ph++) begin
      case (ph)
        0: set_knobs(30,  0,  0,  0, 100, 0);
        1: set_knobs(20, 20,  5,  5,  70, 3);
        2: set_knobs(10, 10, 10, 25,  50, 4);
        3: set_knobs(50,  0,  0, 15, 100, 2);
        4: set_knobs( 0, 30, 15,  0,  20, 1);
        default: set_knobs(25, 15, 10, 10, 60, 5);
      endcase
      if (ph == 2 || ph == 4) do_reset();
      for (int c = 0; c < 600; c++) begin
        cycle();
        // occasional reset landing mid-request
        if (ph == 5 && c == 300) do_reset();
      end
    end

    @(negedge clk);
    check_outputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
